// File: rtl/pixel_stream_receiver_pkg.sv
// Shared constants and helpers for the pixel stream receive path.
package pixel_stream_receiver_pkg;

  localparam int DEF_DATA_WIDTH = 48;
  localparam int DROP_CNT_W     = 16;
  localparam int FRAME_CNT_W    = 32;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pixel_rx_fifo_core.sv
// Dual-pointer RAM FIFO with a registered read port; the read register doubles
// as the downstream output data register.
module pixel_rx_fifo_core
  import pixel_stream_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [clog2(DEPTH):0]   level,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Read-before-write on a shared address: a full FIFO that writes and reads in
  // the same cycle must hand out the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/pixel_stream_receiver.sv
// Link RX to AXI4-Stream bridge: buffers a non-stallable pixel stream, adds
// frame tlast, and reports almost-full, overflow and drop statistics.
module pixel_stream_receiver
  import pixel_stream_receiver_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = 1024,
  parameter int AFULL_MARGIN = 64,
  parameter int FRAME_WORDS  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   m_axi_rx_tdata,
  input  logic                    m_axi_rx_tvalid,
  output logic                    rx_afull,
  output logic [DATA_WIDTH-1:0]   out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic [clog2(DEPTH):0]   fifo_level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count,
  input  logic                    overflow_clr,
  output logic [FRAME_CNT_W-1:0]  frame_count,
  output logic                    frame_done
);

  localparam int AW = clog2(DEPTH);
  localparam int IW = clog2(FRAME_WORDS + 1);
  localparam logic [AW:0]   AFULL_TH = (AW+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_WORDS - 1);

  logic [AW:0]   level;
  logic [AW:0]   level_next;
  logic          full;
  logic          empty;
  logic          handshake;
  logic          load;
  logic          accept;
  logic          drop;
  logic [IW-1:0] word_idx;

  assign handshake = out_tvalid & out_tready;
  assign load      = !empty && (!out_tvalid || out_tready);
  // Full check is against the post-read level, so a load frees a slot this cycle.
  assign accept    = m_axi_rx_tvalid && (!full || load);
  assign drop      = m_axi_rx_tvalid && !accept;

  pixel_rx_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (accept),
    .wr_data (m_axi_rx_tdata),
    .rd_en   (load),
    .rd_data (out_tdata),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign fifo_level = level;

  always_comb begin
    level_next = level;
    if (accept && !load) level_next = level + 1'b1;
    else if (load && !accept) level_next = level - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rx_afull <= 1'b0;
    else          rx_afull <= (level_next >= AFULL_TH);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      word_idx   <= '0;
    end else if (load) begin
      out_tvalid <= 1'b1;
      out_tlast  <= (word_idx == LAST_IDX);
      word_idx   <= (word_idx == LAST_IDX) ? '0 : word_idx + 1'b1;
    end else if (handshake) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= handshake && out_tlast;
      if (handshake && out_tlast) frame_count <= frame_count + 1'b1;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr)         drop_count <= DROP_CNT_W'(1);
      else if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Randomized bench for pixel_stream_receiver against a queue-based reference model.
module tb_pixel_stream_receiver;

  localparam int DW     = 48;
  localparam int DEPTH  = 1024;
  localparam int MARGIN = 64;
  localparam int FW     = 1024;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] m_axi_rx_tdata = '0;
  logic          m_axi_rx_tvalid = 1'b0;
  logic          rx_afull;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
  logic          out_tlast;
  logic [10:0]   fifo_level;
  logic          overflow;
  logic [15:0]   drop_count;
  logic          overflow_clr = 1'b0;
  logic [31:0]   frame_count;
  logic          frame_done;

  pixel_stream_receiver #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_MARGIN (MARGIN),
    .FRAME_WORDS  (FW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .m_axi_rx_tdata  (m_axi_rx_tdata),
    .m_axi_rx_tvalid (m_axi_rx_tvalid),
    .rx_afull        (rx_afull),
    .out_tdata       (out_tdata),
    .out_tvalid      (out_tvalid),
    .out_tready      (out_tready),
    .out_tlast       (out_tlast),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .overflow_clr    (overflow_clr),
    .frame_count     (frame_count),
    .frame_done      (frame_done)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: queue of buffered words plus the presented word
  logic [DW-1:0] q[$];
  logic          m_vld, m_last, m_done, m_ovf;
  logic [DW-1:0] m_data;
  int            m_idx, m_drops;
  logic [31:0]   m_frames;
  int            delivered;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_vld = 0; m_last = 0; m_done = 0; m_ovf = 0;
    m_data = '0; m_idx = 0; m_drops = 0; m_frames = '0;
  endtask

  task automatic compare_all();
    check("tvalid", out_tvalid, m_vld);
    if (m_vld) begin
      check("tdata", out_tdata, m_data);
      check("tlast", out_tlast, m_last);
    end
    check("level", fifo_level, q.size());
    check("afull", rx_afull, q.size() >= DEPTH - MARGIN);
    check("overflow", overflow, m_ovf);
    check("drops", drop_count, m_drops);
    check("frames", frame_count, m_frames);
    check("frame_done", frame_done, m_done);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic hs, load, accept, drop;
    m_axi_rx_tvalid = v;
    m_axi_rx_tdata  = d;
    out_tready      = rdy;
    overflow_clr    = clr;
    hs     = m_vld && rdy;
    load   = (q.size() > 0) && (!m_vld || rdy);
    accept = v && (q.size() < DEPTH || load);
    drop   = v && !accept;
    @(posedge aclk);
    if (hs) delivered++;
    m_done = hs && m_last;
    if (m_done) m_frames = m_frames + 1;
    if (load) begin
      m_data = q.pop_front();
      m_vld  = 1;
      m_last = (m_idx == FW - 1);
      m_idx  = m_last ? 0 : m_idx + 1;
    end else if (hs) begin
      m_vld  = 0;
      m_last = 0;
    end
    if (accept) q.push_back(d);
    if (drop) begin
      m_ovf   = 1;
      m_drops = clr ? 1 : (m_drops == 65535 ? 65535 : m_drops + 1);
    end else if (clr) begin
      m_ovf   = 0;
      m_drops = 0;
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    aresetn = 0;
    m_axi_rx_tvalid = 0; out_tready = 0; overflow_clr = 0; m_axi_rx_tdata = '0;
    #1;
    model_reset();
    compare_all();
    check("rst_tdata", out_tdata, 0);
    check("rst_tlast", out_tlast, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1;
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  initial begin
    int pulses, maxlvl, nvalid, lastpos0, lastpos1, afull_lvl, bound;
    bit seen;

    model_reset();
    do_reset();

    // first-word latency
    step(1, 48'h123456789ABC, 0, 0);
    check("lat_edge_n", out_tvalid, 0);
    step(0, '0, 0, 0);
    check("lat_valid", out_tvalid, 1);
    check("lat_data", out_tdata, 48'h123456789ABC);
    check("lat_last", out_tlast, 0);
    do_reset();

    // continuous streaming
    pulses = 0; maxlvl = 0; nvalid = 0; lastpos0 = -1; lastpos1 = -1;
    for (int i = 0; i < 3005; i++) begin
      step(i < 3000, rnd_word(), 1, 0);
      if (frame_done) pulses++;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      if (out_tvalid) begin
        if (out_tlast) begin
          if (lastpos0 < 0) lastpos0 = nvalid;
          else if (lastpos1 < 0) lastpos1 = nvalid;
        end
        nvalid++;
      end
    end
    check("stream_pulses", pulses, 2);
    check("stream_frames", frame_count, 2);
    check("stream_maxlvl", maxlvl <= 2, 1);
    check("stream_last0", lastpos0, 1023);
    check("stream_last1", lastpos1, 2047);
    check("stream_words", nvalid, 3000);
    do_reset();

    // backpressure to full and overflow
    seen = 0; afull_lvl = 0; delivered = 0;
    for (int i = 0; i < 1030; i++) begin
      step(1, rnd_word(), 0, 0);
      if (!seen && rx_afull) begin
        seen = 1;
        afull_lvl = int'(fifo_level);
      end
    end
    check("afull_level", afull_lvl, 960);
    check("bp_overflow", overflow, 1);
    check("bp_drops", drop_count, 5);
    check("bp_level", fifo_level, 1024);
    step(1, rnd_word(), 1, 0);
    check("full_wr_rd_drops", drop_count, 5);
    check("full_wr_rd_level", fifo_level, 1024);
    bound = 0;
    while ((q.size() > 0 || m_vld) && bound < 5000) begin
      step(0, '0, 1'($urandom_range(0, 1)), 0);
      bound++;
    end
    check("drain_timeout", bound < 5000, 1);
    check("bp_delivered", delivered, 1026);

    // overflow clear and saturation
    step(0, '0, 0, 1);
    check("clr_overflow", overflow, 0);
    check("clr_drops", drop_count, 0);
    for (int i = 0; i < 1025; i++) step(1, rnd_word(), 0, 0);
    check("refill_level", fifo_level, 1024);
    step(1, rnd_word(), 0, 1);
    check("clr_drop_ovf", overflow, 1);
    check("clr_drop_cnt", drop_count, 1);
    for (int i = 0; i < 70000; i++) step(1, rnd_word(), 0, 0);
    check("sat_drops", drop_count, 16'hFFFF);
    do_reset();

    // reset in the middle of a frame
    for (int i = 0; i < 300; i++) step(1, rnd_word(), 1, 0);
    for (int i = 0; i < 200; i++) step(1, rnd_word(), 0, 0);
    check("mid_buffered", fifo_level > 150, 1);
    aresetn = 0;
    #1;
    check("mid_rst_tvalid", out_tvalid, 0);
    check("mid_rst_level", fifo_level, 0);
    do_reset();
    nvalid = 0; lastpos0 = -1;
    for (int i = 0; i < 1030; i++) begin
      step(i < 1024, rnd_word(), 1, 0);
      if (out_tvalid) begin
        if (out_tlast && lastpos0 < 0) lastpos0 = nvalid;
        nvalid++;
      end
    end
    check("post_rst_last", lastpos0, 1023);
    check("post_rst_frames", frame_count, 1);

    // random traffic mix
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_word(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
